// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong score/serve control path.
package pong_pkg;

    localparam int unsigned DEF_SCORE_W   = 4;
    localparam int unsigned DEF_WIN_SCORE = 5;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        GOAL,
        OVER
    } state_t;

    // serve_dir encoding: the serve always heads toward the player who conceded
    localparam logic DIR_TO_P1 = 1'b0;
    localparam logic DIR_TO_P2 = 1'b1;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done rises once the loaded number of cycles has elapsed.
module hold_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    // done is kept equal to (cnt == 0) but registered, so it lines up with the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (load) begin
            cnt  <= (value != '0) ? value - W'(1) : '0;
            done <= (value <= W'(1));
        end else if (cnt != '0) begin
            cnt  <= cnt - W'(1);
            done <= (cnt == W'(1));
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Scores ball-out events, emits goal/win pulses for the animation and gates play.
// Optional build macro SCORE_WIN_BY_TWO_EN: a win additionally requires a 2-point lead.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
    parameter int unsigned SCORE_W     = DEF_SCORE_W,
    parameter int unsigned GOAL_HOLD   = 32,
    parameter int unsigned SERVE_DELAY = 8
) (
    input  logic               BALL_CLOCK,
    input  logic               RESET_N,
    input  logic               ball_out_left,
    input  logic               ball_out_right,
    input  logic               new_game,
    output logic               goal_player_1,
    output logic               goal_player_2,
    output logic               win_player_1,
    output logic               win_player_2,
    output logic [SCORE_W-1:0] score_player_1,
    output logic [SCORE_W-1:0] score_player_2,
    output logic               serve_en,
    output logic               serve_dir,
    output logic               game_over
);

    localparam int unsigned HOLD_MAX = (GOAL_HOLD > SERVE_DELAY) ? GOAL_HOLD : SERVE_DELAY;
    localparam int unsigned TIMER_W  = $clog2(HOLD_MAX + 1);

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [SCORE_W:0]   wide_t;
    typedef logic [TIMER_W-1:0] tval_t;

    state_t state;
    logic   ng_q;
    logic   ng_rise_c;
    logic   pt1_c;
    logic   pt2_c;
    logic   both_c;
    logic   win1_c;
    logic   win2_c;
    score_t inc1_c;
    score_t inc2_c;
    logic   timer_load_c;
    tval_t  timer_value_c;
    logic   timer_done;

    // Event decode and saturating next-score / win evaluation
    always_comb begin
        ng_rise_c = new_game & ~ng_q;
        both_c    = ball_out_left & ball_out_right;
        pt1_c     = ball_out_right & ~ball_out_left;
        pt2_c     = ball_out_left & ~ball_out_right;
        inc1_c    = (&score_player_1) ? score_player_1 : score_player_1 + score_t'(1);
        inc2_c    = (&score_player_2) ? score_player_2 : score_player_2 + score_t'(1);
`ifdef SCORE_WIN_BY_TWO_EN
        // a leader stuck at saturation wins on the next point
        win1_c = ((wide_t'(inc1_c) >= wide_t'(WIN_SCORE)) &&
                  (wide_t'(inc1_c) >= wide_t'(score_player_2) + wide_t'(2))) ||
                 ((&score_player_1) && (score_player_1 > score_player_2));
        win2_c = ((wide_t'(inc2_c) >= wide_t'(WIN_SCORE)) &&
                  (wide_t'(inc2_c) >= wide_t'(score_player_1) + wide_t'(2))) ||
                 ((&score_player_2) && (score_player_2 > score_player_1));
`else
        win1_c = (wide_t'(inc1_c) >= wide_t'(WIN_SCORE));
        win2_c = (wide_t'(inc2_c) >= wide_t'(WIN_SCORE));
`endif
    end

    // One timer serves both SERVE and GOAL; load it on entry to either
    always_comb begin
        timer_load_c  = 1'b0;
        timer_value_c = tval_t'(SERVE_DELAY);
        if (ng_rise_c) begin
            timer_load_c = 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (both_c) begin
                        timer_load_c = 1'b1;
                    end else if ((pt1_c && !win1_c) || (pt2_c && !win2_c)) begin
                        timer_load_c  = 1'b1;
                        timer_value_c = tval_t'(GOAL_HOLD);
                    end
                end
                GOAL: timer_load_c = timer_done;
                default: ;
            endcase
        end
    end

    hold_timer #(
        .W(TIMER_W)
    ) u_hold_timer (
        .clk  (BALL_CLOCK),
        .rst_n(RESET_N),
        .load (timer_load_c),
        .value(timer_value_c),
        .done (timer_done)
    );

    // Game FSM with registered scores, pulses and play gating
    always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            ng_q           <= 1'b0;
            score_player_1 <= '0;
            score_player_2 <= '0;
            goal_player_1  <= 1'b0;
            goal_player_2  <= 1'b0;
            win_player_1   <= 1'b0;
            win_player_2   <= 1'b0;
            serve_en       <= 1'b0;
            serve_dir      <= DIR_TO_P1;
            game_over      <= 1'b0;
        end else begin
            ng_q          <= new_game;
            goal_player_1 <= 1'b0;
            goal_player_2 <= 1'b0;
            win_player_1  <= 1'b0;
            win_player_2  <= 1'b0;
            if (ng_rise_c) begin
                state          <= SERVE;
                score_player_1 <= '0;
                score_player_2 <= '0;
                serve_en       <= 1'b0;
                game_over      <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    SERVE: begin
                        if (timer_done) begin
                            state    <= PLAY;
                            serve_en <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (both_c) begin
                            state    <= SERVE;
                            serve_en <= 1'b0;
                        end else if (pt1_c) begin
                            score_player_1 <= inc1_c;
                            serve_dir      <= DIR_TO_P2;
                            serve_en       <= 1'b0;
                            if (win1_c) begin
                                win_player_1 <= 1'b1;
                                game_over    <= 1'b1;
                                state        <= OVER;
                            end else begin
                                goal_player_1 <= 1'b1;
                                state         <= GOAL;
                            end
                        end else if (pt2_c) begin
                            score_player_2 <= inc2_c;
                            serve_dir      <= DIR_TO_P1;
                            serve_en       <= 1'b0;
                            if (win2_c) begin
                                win_player_2 <= 1'b1;
                                game_over    <= 1'b1;
                                state        <= OVER;
                            end else begin
                                goal_player_2 <= 1'b1;
                                state         <= GOAL;
                            end
                        end
                    end
                    GOAL: begin
                        if (timer_done) begin
                            state <= SERVE;
                        end
                    end
                    OVER: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream stage of the LED animation block. It turns raw ball-out events from the ball/paddle logic into per-player scores and into one-cycle goal/win pulses that drive the animation.
- It also gates play, so the ball logic stays stopped while an animation runs and after a game is won.
- The pulse names and the meaning of each pulse match the animation inputs exactly: goal_player_1 means player 1 scored.

Parameters:
- WIN_SCORE, 5: points needed to win; must be ≤ 2^SCORE_W−1.
- SCORE_W, 4: width of each score counter.
- GOAL_HOLD, 32: BALL_CLOCK cycles play stays frozen after a goal. Must be ≥ 26, which covers one goal animation pass.
- SERVE_DELAY, 8: cycles in SERVE before the ball is released.

Ports:
- BALL_CLOCK  in  1  sole clock, same clock as the animation block
- RESET_N  in  1  asynchronous, active-low reset
- ball_out_left  in  1  ball passed player 1's (left) edge, so player 2 scores
- ball_out_right  in  1  ball passed player 2's (right) edge, so player 1 scores
- new_game  in  1  level input from a debounced button; acts on its rising edge
- goal_player_1  out  1  one-cycle pulse when player 1 scores a non-winning point
- goal_player_2  out  1  one-cycle pulse when player 2 scores a non-winning point
- win_player_1  out  1  one-cycle pulse when player 1 wins
- win_player_2  out  1  one-cycle pulse when player 2 wins
- score_player_1  out  SCORE_W  current score of player 1
- score_player_2  out  SCORE_W  current score of player 2
- serve_en  out  1  high only in PLAY; ball logic moves only while it is high
- serve_dir  out  1  direction of the next serve: 0 = toward player 1, 1 = toward player 2
- game_over  out  1  high in OVER

Behaviour:
- Reset state (while RESET_N is low, applied asynchronously):
  - state = IDLE, both scores = 0.
  - All pulses = 0, serve_en = 0, game_over = 0, serve_dir = 0.
  - The new_game edge register is loaded from 0.
- State machine:
  - IDLE → SERVE on a new_game rising edge. Scores are cleared.
  - SERVE: a timer counts SERVE_DELAY cycles, then the FSM moves to PLAY.
  - PLAY: serve_en = 1. A scoring event is exactly one of ball_out_left / ball_out_right high.
    - If the new score equals WIN_SCORE, go to OVER.
    - Otherwise go to GOAL.
  - GOAL: a timer counts GOAL_HOLD cycles, then the FSM moves to SERVE.
  - OVER: game_over = 1. Leaves only on a new_game rising edge: scores are cleared, then SERVE.
- Pulse timing:
  - An event sampled at edge N produces a score increment and the matching pulse, both registered at edge N.
  - The pulse is therefore high for exactly the cycle between edges N and N+1.
  - serve_en drops at the same edge N.
- Pulse exclusivity: at most one of the four pulses is high in any cycle. A winning point asserts only win_player_x, never goal_player_x as well, because the animation lets a goal input override a win input.
- serve_dir is set to the player who conceded the point, so the serve goes toward the loser.
- Boundary cases:
  - ball_out_left and ball_out_right high in the same PLAY cycle: no score, no pulse. Go to SERVE with serve_dir unchanged.
  - ball_out_* outside PLAY is ignored.
  - A new_game rising edge in any state (including PLAY, GOAL and SERVE) clears the scores and goes to SERVE. It takes priority over a ball_out event in the same cycle, and no pulse is emitted.
  - Score counters saturate at 2^SCORE_W−1 and never wrap.
  - If RESET_N is asserted mid-hold, the timer and FSM return to IDLE immediately.

Optional Feature:
- Macro: SCORE_WIN_BY_TWO_EN.
- When defined: a player wins only when their score is ≥ WIN_SCORE and they lead by at least 2. A point at WIN_SCORE without a 2-point lead is an ordinary goal (GOAL state, goal pulse). Counters still saturate; if saturation is reached without a 2-point lead, the next point for the leader wins.
- When undefined: the first player to reach WIN_SCORE wins.

Decomposition:
- Package pong_pkg holds:
  - the state enum (IDLE, SERVE, PLAY, GOAL, OVER);
  - the default SCORE_W and WIN_SCORE;
  - the serve_dir encoding constants.
- Sub-module hold_timer: a loadable down-counter with inputs load/value and output done. It is instantiated once and shared by SERVE and GOAL.

Test Plan:
- Reset, then pulse new_game → after 8 cycles serve_en = 1, both scores = 0, game_over = 0.
- In PLAY, drive ball_out_right for 1 cycle →
  - score_player_1 = 1 and goal_player_1 high for exactly 1 cycle;
  - serve_dir = 1;
  - serve_en low for 32 + 8 cycles, then high again.
- Play player 2 to 4 points, then give player 2 one more →
  - win_player_2 pulses once and goal_player_2 stays 0;
  - game_over = 1;
  - further ball_out events are ignored;
  - new_game clears both scores and the FSM re-enters SERVE.
- Both ball_out inputs high together in PLAY → no pulse, scores unchanged, FSM goes to SERVE.
- new_game rising in the same cycle as ball_out_left during PLAY → scores = 0, no pulse. Asserting RESET_N low mid-GOAL returns all outputs to their reset values at once.
- With SCORE_WIN_BY_TWO_EN defined and the score at 4–4, give player 1 a point → score 5–4 with goal_player_1 only; give player 1 another point → 6–4 and win_player_1 pulses.
